// File: rtl/addsub_serial.sv
// ---------------------------------------------------------------------------
// addsub_serial -- digit-serial adder/subtractor
//
// Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB first,
// through one DIGIT-bit adder slice with a registered carry. An operation
// takes N = WIDTH/DIGIT cycles. The results are held until the next accepted
// start.
//
// Parameters
//   WIDTH  operand/result width; must be a positive multiple of DIGIT
//   DIGIT  bits processed per clock
//
// Optional feature
//   ADDSUB_SERIAL_OVF_EN  when defined, V reports signed overflow.
//                         When undefined, V is held at 0.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request, sampled in IDLE or DONE
//   A      in   operand A
//   B      in   operand B
//   M      in   mode: 0 = A+B, 1 = A-B
//   busy   out  operation in progress
//   done   out  one-cycle pulse; S/Cout/V valid
//   S      out  sum / difference, modulo 2^WIDTH
//   Cout   out  carry out of MSB (for A-B: 1 = no borrow)
//   V      out  signed overflow
// ---------------------------------------------------------------------------
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             M,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic             load_s;
    logic             step_s;
    logic             last_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;

    logic [DIGIT:0]   slice_s;
    logic [WIDTH-1:0] sum_ext_s;
    logic [WIDTH-1:0] s_shift_s;

    // Next-state and control decode for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        step_s     = 1'b0;
        last_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s     = 1'b1;
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                // start is deliberately ignored here
                step_s = 1'b1;
                if (cnt_r == LAST_DIGIT) begin
                    last_s     = 1'b1;
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                // A start here is accepted at once, so back-to-back
                // operations need no idle cycle
                if (start) begin
                    load_s     = 1'b1;
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // One DIGIT-bit slice of the adder; the new digit enters S at the MSB end
    always_comb begin
        slice_s   = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_r};
        sum_ext_s = '0;
        sum_ext_s[DIGIT-1:0] = slice_s[DIGIT-1:0];
        s_shift_s = (s_r >> DIGIT) | (sum_ext_s << (WIDTH - DIGIT));
    end

    // Sequencer state plus the registered busy/done flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == RUN);
            done_r  <= (state_nx_s == DONE);
        end
    end

    // Operand shifters, carry, digit counter, and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            s_r     <= '0;
            cout_r  <= 1'b0;
        end else if (load_s) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with M
            a_r     <= A;
            b_r     <= B ^ {WIDTH{M}};
            carry_r <= M;
            cnt_r   <= '0;
            s_r     <= '0;
            cout_r  <= 1'b0;
        end else if (step_s) begin
            a_r     <= a_r >> DIGIT;
            b_r     <= b_r >> DIGIT;
            carry_r <= slice_s[DIGIT];
            cnt_r   <= cnt_r + CW'(1);
            s_r     <= s_shift_s;
            if (last_s) begin
                cout_r <= slice_s[DIGIT];
            end else begin
                cout_r <= cout_r;
            end
        end else begin
            a_r     <= a_r;
            b_r     <= b_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
            s_r     <= s_r;
            cout_r  <= cout_r;
        end
    end

`ifdef ADDSUB_SERIAL_OVF_EN
    logic v_r;
    logic msb_cin_s;

    // The carry into the MSB is recovered from the slice's top sum bit.
    // This works for any DIGIT, including DIGIT=1.
    always_comb begin
        msb_cin_s = slice_s[DIGIT-1] ^ a_r[DIGIT-1] ^ b_r[DIGIT-1];
    end

    // Signed-overflow flag, captured on the final digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r <= 1'b0;
        end else if (load_s) begin
            v_r <= 1'b0;
        end else if (last_s) begin
            v_r <= msb_cin_s ^ slice_s[DIGIT];
        end else begin
            v_r <= v_r;
        end
    end

    assign V = v_r;
`else
    assign V = 1'b0;
`endif

    assign busy = busy_r;
    assign done = done_r;
    assign S    = s_r;
    assign Cout = cout_r;

endmodule

// File: tb/tb_addsub_serial.sv
// ---------------------------------------------------------------------------
// tb_addsub_serial -- self-checking bench for addsub_serial.
// Instantiates one WIDTH=8/DIGIT=1 unit and one WIDTH=8/DIGIT=4 unit.
// Expected results come from plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_addsub_serial;

    localparam logic OVF =
`ifdef ADDSUB_SERIAL_OVF_EN
        1'b1;
`else
        1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start4;
    logic [7:0] a1, b1, a4, b4;
    logic       m1, m4;
    logic       busy1, done1, c1, v1;
    logic       busy4, done4, c4, v4;
    logic [7:0] s1, s4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .M(m1),
        .busy(busy1), .done(done1), .S(s1), .Cout(c1), .V(v1)
    );

    addsub_serial #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .M(m4),
        .busy(busy4), .done(done4), .S(s4), .Cout(c4), .V(v4)
    );

    typedef struct {
        logic       wide;
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
        logic [7:0] s;
        logic       c;
        logic       v;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: integer add/subtract, then the carry and signed-overflow rules
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic m,
                         output logic [7:0] s, output logic c, output logic v);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = a[7] ? ua - 256 : ua;
        sb = b[7] ? ub - 256 : ub;
        ur = m ? ua - ub : ua + ub;
        sr = m ? sa - sb : sa + sb;
        s  = ur[7:0];
        c  = m ? (ua >= ub) : (ur > 255);
        v  = OVF & ((sr > 127) || (sr < -128));
    endtask

    // Issues one operation (the caller is #1 after an edge) and waits for done
    task automatic run_op(input logic wide, input logic [7:0] a, input logic [7:0] b,
                          input logic m, output logic [7:0] s, output logic c,
                          output logic v, output int lat);
        logic got;
        if (wide) begin
            a4 = a; b4 = b; m4 = m; start4 = 1'b1;
        end else begin
            a1 = a; b1 = b; m1 = m; start1 = 1'b1;
        end
        @(posedge clk); #1;
        start1 = 1'b0;
        start4 = 1'b0;
        chk("busy_after_accept", wide ? busy4 : busy1, 1);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (wide ? done4 : done1) got = 1'b1;
        end
        if (!got) chk("done_timeout", 0, 1);
        s = wide ? s4 : s1;
        c = wide ? c4 : c1;
        v = wide ? v4 : v1;
    endtask

    task automatic chk_op(input string tag, input logic wide, input logic [7:0] a,
                          input logic [7:0] b, input logic m);
        logic [7:0] s, es;
        logic       c, v, ec, ev;
        int         lat;
        model(a, b, m, es, ec, ev);
        run_op(wide, a, b, m, s, c, v, lat);
        chk({tag, "_S"}, s, es);
        chk({tag, "_Cout"}, c, ec);
        chk({tag, "_V"}, v, ev);
        chk({tag, "_lat"}, lat, wide ? 2 : 8);
    endtask

    initial begin
        vec_t       vecs[4];
        logic [7:0] s;
        logic       c, v;
        int         lat, pulses;
        logic [7:0] s_at_done;

        vecs[0] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8};
        vecs[1] = '{1'b0, 8'h04, 8'h05, 1'b1, 8'hFF, 1'b0, 1'b0, 8};
        vecs[2] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF,  8};
        vecs[3] = '{1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 2};

        rst = 1'b1;
        start1 = 1'b0; start4 = 1'b0;
        a1 = 8'h00; b1 = 8'h00; m1 = 1'b0;
        a4 = 8'h00; b4 = 8'h00; m4 = 1'b0;
        #1;
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_S", s1, 0);
        chk("rst_Cout", c1, 0);
        chk("rst_V", v1, 0);
        chk("rst_busy4", busy4, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors, with an idle cycle after each to check that results are held
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].wide, vecs[i].a, vecs[i].b, vecs[i].m, s, c, v, lat);
            chk($sformatf("vec%0d_S", i), s, vecs[i].s);
            chk($sformatf("vec%0d_Cout", i), c, vecs[i].c);
            chk($sformatf("vec%0d_V", i), v, vecs[i].v);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_pulse", i), vecs[i].wide ? done4 : done1, 0);
            chk($sformatf("vec%0d_idle_busy", i), vecs[i].wide ? busy4 : busy1, 0);
            chk($sformatf("vec%0d_held_S", i), vecs[i].wide ? s4 : s1, vecs[i].s);
        end

        // Back-to-back: the second start is issued in the DONE cycle
        run_op(1'b0, 8'h07, 8'h08, 1'b0, s, c, v, lat);
        chk("b2b1_S", s, 8'h0F);
        chk("b2b1_Cout", c, 0);
        run_op(1'b0, 8'h04, 8'h04, 1'b1, s, c, v, lat);
        chk("b2b2_S", s, 8'h00);
        chk("b2b2_Cout", c, 1);
        chk("b2b2_lat", lat, 8);
        @(posedge clk); #1;

        // A start pulse and operand changes mid-RUN are ignored
        a1 = 8'h10; b1 = 8'h01; m1 = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a1 = 8'hAA; b1 = 8'h55; m1 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        pulses = 0;
        s_at_done = 8'h00;
        for (int i = 0; i < 12; i++) begin
            if (done1) begin
                pulses++;
                s_at_done = s1;
            end
            @(posedge clk); #1;
        end
        chk("midrun_pulses", pulses, 1);
        chk("midrun_S", s_at_done, 8'h11);
        chk("midrun_idle", busy1, 0);

        // Reset during RUN clears everything at once and discards the operation
        a1 = 8'hFF; b1 = 8'h00; m1 = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", busy1, 0);
        chk("midrst_S", s1, 0);
        chk("midrst_done", done1, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done1) pulses++;
        end
        chk("midrst_no_done", pulses, 0);

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            chk_op("rnd1", 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            if (($urandom % 2) == 0) begin
                @(posedge clk); #1;
            end
        end
        for (int i = 0; i < 20; i++) begin
            chk_op("rnd4", 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised digit-serial adder-subtractor, the sequential successor to the 4-bit combinational adder-subtractor in the comb-logic exercises. It accepts two WIDTH-bit operands and a mode bit under a start/busy/done handshake. It processes DIGIT bits per clock from LSB to MSB through a single DIGIT-bit adder slice with a registered carry. Results are S, Cout and an optional signed-overflow flag V, held stable until the next accepted start.

## Interface
- WIDTH, 8, operand/result width in bits; must be a positive multiple of DIGIT
- DIGIT, 1, bits processed per cycle; N = WIDTH/DIGIT cycles per operation
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising clk edge
- A  input  WIDTH  operand A (unsigned/two's complement)
- B  input  WIDTH  operand B
- M  input  1  mode: 0 = A+B, 1 = A−B
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, results valid
- S  output  WIDTH  sum/difference
- Cout  output  1  carry out of MSB (for M=1: 1 = no borrow, A ≥ B unsigned)
- V  output  1  signed overflow

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; busy=0, done=0, S=0, Cout=0, V=0, digit counter=0, carry=0.
- IDLE or DONE, start=1: latch A, B XOR {WIDTH{M}}, carry ← M, counter ← 0; clear S, Cout and V; go to RUN.
- IDLE, start=0: stay. DONE, start=0: go to IDLE; results are held.
- RUN, each cycle:
  - DIGIT-bit sum = A_reg[DIGIT-1:0] + B_reg[DIGIT-1:0] + carry.
  - Sum shifts into S from the MSB end; S shifts right by DIGIT.
  - A_reg and B_reg shift right by DIGIT; carry ← slice carry; counter increments.
- RUN, on the N-th digit: Cout ← slice carry-out; V ← carry into MSB XOR carry out of MSB; go to DONE.
- start is ignored while in RUN. Operands are not re-sampled, and no error is raised.
- A, B and M are only sampled on an accepted start; changing them during RUN has no effect.
- Arithmetic is modulo 2^WIDTH; S is exactly (A ± B) mod 2^WIDTH.
- rst asserted at any time, including mid-RUN, forces the reset values immediately. The partial result is discarded.

## Timing
- start accepted at edge k: busy=1 from after edge k until after edge k+N.
- After edge k+N: state = DONE, busy=0, done=1 for exactly one cycle; S, Cout and V are valid.
- Latency from accepting edge to done: N cycles. Throughput: one operation per N+1 cycles.
- A start sampled while in DONE is accepted on that edge, giving back-to-back operations with no idle cycle.
- S is a shifting partial value during RUN. It is only meaningful when done=1, or in IDLE after a completed operation.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- Macro ADDSUB_SERIAL_OVF_EN.
- Defined: V is computed as specified. Implementations with DIGIT=1 capture the MSB carry-in from the final slice.
- Undefined: overflow logic is omitted and V is tied to 0 in every state. The V port remains present so benches bind identically.

## Test plan
- WIDTH=8, DIGIT=1; reset, then start with A=0x00, B=0x00, M=0 → done exactly 8 cycles after accept; S=0x00, Cout=0, V=0.
- A=0x07, B=0x08, M=0 → S=0x0F, Cout=0. Then A=0x04, B=0x04, M=1 issued in the DONE cycle → S=0x00, Cout=1, no idle gap.
- A=0x04, B=0x05, M=1 → S=0xFF, Cout=0, V=0.
- A=0x7F, B=0x01, M=0 → S=0x80, Cout=0; V=1 with the macro defined, V=0 with it undefined.
- A=0x10, B=0x01, M=0, with a start pulse at cycle 3 of RUN and A/B changed mid-RUN → result S=0x11, single done pulse. Separately, rst at cycle 4 of RUN → busy=0, S=0, no done.
- WIDTH=8, DIGIT=4; A=0xFF, B=0x01, M=0 → done 2 cycles after accept; S=0x00, Cout=1, V=0.
